// File: rtl/sma_agu_if.sv
// Command-walker interface: host config/start lines plus memory-side
// handshake and status back from the address generator.
interface sma_agu_if #(
    parameter int AW = 32,
    parameter int SW = 16,
    parameter int CW = 16
);
    logic          run;
    logic          abort;
    logic          cen;
    logic [AW-1:0] adl;
    logic [AW-1:0] adh;
    logic [SW-1:0] stride;
    logic [CW-1:0] reps;
    logic          rdy;
    logic          bzy;
    logic          cmd;
    logic [AW-1:0] add;
    logic          done;
    logic          err;
    logic [CW-1:0] cnt;

    modport master (
        output run, abort, cen, adl, adh, stride, reps, rdy,
        input  bzy, cmd, add, done, err, cnt
    );

    modport slave (
        input  run, abort, cen, adl, adh, stride, reps, rdy,
        output bzy, cmd, add, done, err, cnt
    );
endinterface

// File: rtl/sma_agu.sv
// Strided address walker: issues one memory command per address from adl
// to adh (inclusive) with a programmable stride, repeated for reps passes.
module sma_agu #(
    parameter int AW = 32,
    parameter int SW = 16,
    parameter int CW = 16
) (
    input logic       clk,
    input logic       rst_n,
    sma_agu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t        state;
    logic          run_q;
    logic          err_r;
    logic [AW-1:0] adl_l;
    logic [AW-1:0] adh_l;
    logic [AW-1:0] add_r;
    logic [SW-1:0] stride_l;
    logic [CW-1:0] reps_l;
    logic [CW-1:0] pass_l;
    logic [CW-1:0] cnt_r;

    logic          run_edge;
    logic          cmd_w;
    logic          bad_cfg;
    logic          pass_end;
    logic [AW:0]   nxt;

    assign run_edge = bus.run & ~run_q;
    assign cmd_w    = (state == ISSUE) & bus.rdy & bus.cen & ~bus.abort;
    assign bad_cfg  = (bus.adh < bus.adl) | (bus.stride == '0);

    // Extra carry bit catches wrap past the top of the address space.
    assign nxt      = {1'b0, add_r} + (AW+1)'(stride_l);
    assign pass_end = nxt[AW] | (nxt[AW-1:0] > adh_l);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            err_r    <= 1'b0;
            adl_l    <= '0;
            adh_l    <= '0;
            add_r    <= '0;
            stride_l <= '0;
            reps_l   <= '0;
            pass_l   <= '0;
            cnt_r    <= '0;
        end else begin
            run_q <= bus.run;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_edge) begin
                        adl_l    <= bus.adl;
                        adh_l    <= bus.adh;
                        stride_l <= bus.stride;
                        reps_l   <= bus.reps;
                        pass_l   <= bus.reps;
                        add_r    <= bus.adl;
                        cnt_r    <= '0;
                        if (bad_cfg) err_r <= 1'b1;
                        else         state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (cmd_w) begin
                        cnt_r <= cnt_r + CW'(1);
                        if (!pass_end) begin
                            add_r <= nxt[AW-1:0];
                        end else if (reps_l != '0 && pass_l == CW'(1)) begin
                            state <= FIN;
                        end else begin
                            // reps==0 means endless: pass counter is left alone
                            if (reps_l != '0) pass_l <= pass_l - CW'(1);
                            add_r <= adl_l;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort)                state <= IDLE;
                    else if (bus.rdy && bus.cen)  state <= ISSUE;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd  = cmd_w;
    assign bus.add  = add_r;
    assign bus.cnt  = cnt_r;
    assign bus.err  = err_r;
    assign bus.bzy  = (state != IDLE);
    assign bus.done = (state == FIN);
endmodule

// File: tb/tb_sma_agu.sv
// Directed bench for sma_agu: walks, multi-pass, stalls, rejects, abort,
// async reset and a randomised rdy/cen run against a small reference model.
module tb_sma_agu;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    sma_agu_if #(.AW(32), .SW(16), .CW(16)) bus ();

    sma_agu #(.AW(32), .SW(16), .CW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] lo, input logic [31:0] hi,
                         input logic [15:0] st, input logic [15:0] rp);
        bus.adl    = lo;
        bus.adh    = hi;
        bus.stride = st;
        bus.reps   = rp;
        bus.run    = 1'b1;
        cyc();
        bus.run    = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic [31:0] a);
        #2;
        chk({tag, "_cmd"}, bus.cmd, 1'b1);
        chk({tag, "_add"}, bus.add, a);
        cyc();
    endtask

    task automatic expect_done(input string tag, input logic [15:0] n);
        #2;
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_fin_bzy"}, bus.bzy, 1'b1);
        chk({tag, "_fin_cmd"}, bus.cmd, 1'b0);
        chk({tag, "_cnt"}, bus.cnt, n);
        cyc();
        #2;
        chk({tag, "_idle_bzy"}, bus.bzy, 1'b0);
        chk({tag, "_idle_done"}, bus.done, 1'b0);
        cyc();
    endtask

    logic        r, c, e, m_issue, fin;
    logic [31:0] m_add;
    int          m_pass;

    initial begin
        rst_n      = 1'b0;
        bus.run    = 1'b0;
        bus.abort  = 1'b0;
        bus.cen    = 1'b0;
        bus.rdy    = 1'b0;
        bus.adl    = '0;
        bus.adh    = '0;
        bus.stride = '0;
        bus.reps   = '0;
        #3;
        chk("rst_bzy",  bus.bzy,  1'b0);
        chk("rst_cmd",  bus.cmd,  1'b0);
        chk("rst_add",  bus.add,  32'h0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err",  bus.err,  1'b0);
        chk("rst_cnt",  bus.cnt,  16'h0);
        cyc();
        cyc();
        rst_n   = 1'b1;
        bus.rdy = 1'b1;
        bus.cen = 1'b1;
        cyc();

        // T1: plain walk 0x10..0x14
        start(32'h10, 32'h14, 16'd1, 16'd1);
        for (int i = 0; i < 5; i++) expect_cmd("t1", 32'h10 + i);
        expect_done("t1", 16'd5);

        // T2: stride 3 must stop at 9, never exceed adh=10
        start(32'd0, 32'd10, 16'd3, 16'd1);
        expect_cmd("t2", 32'd0);
        expect_cmd("t2", 32'd3);
        expect_cmd("t2", 32'd6);
        expect_cmd("t2", 32'd9);
        expect_done("t2", 16'd4);

        // T3a: two passes
        start(32'd4, 32'd5, 16'd1, 16'd2);
        expect_cmd("t3", 32'd4);
        expect_cmd("t3", 32'd5);
        expect_cmd("t3", 32'd4);
        expect_cmd("t3", 32'd5);
        expect_done("t3", 16'd4);

        // T3b: endless until abort
        start(32'd4, 32'd5, 16'd1, 16'd0);
        expect_cmd("t3e", 32'd4);
        expect_cmd("t3e", 32'd5);
        expect_cmd("t3e", 32'd4);
        expect_cmd("t3e", 32'd5);
        expect_cmd("t3e", 32'd4);
        bus.abort = 1'b1;
        #2;
        chk("t3e_abort_cmd", bus.cmd, 1'b0);
        cyc();
        bus.abort = 1'b0;
        #2;
        chk("t3e_abort_bzy",  bus.bzy,  1'b0);
        chk("t3e_abort_done", bus.done, 1'b0);
        chk("t3e_abort_cnt",  bus.cnt,  16'd5);
        chk("t3e_abort_add",  bus.add,  32'd5);
        cyc();

        // T4: rdy low for 3 cycles at add=0x12, one resume bubble
        start(32'h10, 32'h14, 16'd1, 16'd1);
        expect_cmd("t4", 32'h10);
        expect_cmd("t4", 32'h11);
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t4_stall_cmd", bus.cmd, 1'b0);
            chk("t4_stall_add", bus.add, 32'h12);
            cyc();
        end
        bus.rdy = 1'b1;
        #2;
        chk("t4_bubble_cmd", bus.cmd, 1'b0);
        cyc();
        expect_cmd("t4", 32'h12);
        expect_cmd("t4", 32'h13);
        expect_cmd("t4", 32'h14);
        expect_done("t4", 16'd5);

        // T5: rejected starts
        start(32'd7, 32'd3, 16'd1, 16'd1);
        #2;
        chk("t5_err",     bus.err, 1'b1);
        chk("t5_err_bzy", bus.bzy, 1'b0);
        chk("t5_err_cmd", bus.cmd, 1'b0);
        cyc();
        #2;
        chk("t5_err_pulse", bus.err, 1'b0);
        cyc();
        start(32'd0, 32'd5, 16'd0, 16'd1);
        #2;
        chk("t5_s0_err", bus.err, 1'b1);
        chk("t5_s0_bzy", bus.bzy, 1'b0);
        cyc();
        cyc();
        // T5: top of address space, stride overflows -> single command
        start(32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'd2, 16'd1);
        expect_cmd("t5_top", 32'hFFFF_FFFE);
        expect_done("t5_top", 16'd1);

        // T6a: run edge while busy ignored, new inputs unused
        start(32'h10, 32'h14, 16'd1, 16'd1);
        expect_cmd("t6", 32'h10);
        bus.run = 1'b1;
        bus.adl = 32'h100;
        bus.adh = 32'h200;
        expect_cmd("t6", 32'h11);
        bus.run = 1'b0;
        #2;
        chk("t6_no_err", bus.err, 1'b0);
        cyc();
        expect_cmd("t6", 32'h13);
        expect_cmd("t6", 32'h14);
        expect_done("t6", 16'd5);

        // T6b: async reset mid-sequence
        start(32'h10, 32'h14, 16'd1, 16'd1);
        expect_cmd("t6r", 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6r_cmd", bus.cmd, 1'b0);
        chk("t6r_bzy", bus.bzy, 1'b0);
        chk("t6r_add", bus.add, 32'h0);
        chk("t6r_cnt", bus.cnt, 16'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // T6c: random rdy/cen against a reference walk 0x20,0x23,0x26 x3
        start(32'h20, 32'h27, 16'd3, 16'd3);
        m_issue = 1'b1;
        m_add   = 32'h20;
        m_pass  = 3;
        fin     = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) != 0);
            bus.rdy = r;
            bus.cen = c;
            #2;
            e = m_issue & r & c;
            chk("rnd_cmd", bus.cmd, e);
            if (e) begin
                chk("rnd_add", bus.add, m_add);
                if (m_add + 32'd3 <= 32'h27) m_add = m_add + 32'd3;
                else if (m_pass == 1) fin = 1'b1;
                else begin
                    m_pass--;
                    m_add = 32'h20;
                end
            end else if (m_issue) begin
                m_issue = 1'b0;
            end else if (r & c) begin
                m_issue = 1'b1;
            end
            cyc();
        end
        bus.rdy = 1'b1;
        bus.cen = 1'b1;
        expect_done("rnd", 16'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
